signal_conditioner: RTL and testbench
=====================================

Name: signal_conditioner

Overview:
- Input front-end that sits directly upstream of the first-signal detector and drives its a, b, c inputs.
- Each of three asynchronous raw lines passes through a synchronizer and then a debouncer, so the detector sees only clean, clock-aligned levels.
- Short pulses rejected by the debouncer are counted in a saturating glitch counter for diagnostics.

Parameters:
- SYNC_STAGES, 2, flip-flops in each synchronizer chain (legal values 2 to 4).
- DEBOUNCE_CYCLES, 4, consecutive cycles a new synchronized level must persist before the output follows it (legal values 1 to 255).
- GLITCH_W, 8, width of the glitch counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  conditioner enable
- clr_glitch  in  1  synchronous clear of glitch_count
- a_raw  in  1  raw asynchronous input, channel a
- b_raw  in  1  raw asynchronous input, channel b
- c_raw  in  1  raw asynchronous input, channel c
- a  out  1  debounced level, channel a; feeds detector a
- b  out  1  debounced level, channel b; feeds detector b
- c  out  1  debounced level, channel c; feeds detector c
- glitch_count  out  GLITCH_W  saturating count of rejected pulses

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all synchronizer flops, debounce counters, a/b/c and glitch_count clear to 0 at the next clk edge with rst=1.
  - rst overrides en and clr_glitch.
  - Reset mid-debounce discards the partial count.
- Synchronizer: raw input is delayed SYNC_STAGES cycles to give syncd. It always runs, including when en=0. Reset value is 0.
- Debounce, per channel, registered on every clock edge:
  - cnt is 8 bits.
  - If syncd == out: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: out <= syncd and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: if raw changes before edge 0 and stays stable, out changes after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults, out is valid after edge 5. Falling edges use the same path and the same latency.
- Glitch detection: a channel flags a glitch in a cycle when syncd == out and cnt != 0. This means a differing run ended before it was accepted. Runs that reach acceptance are not glitches.
- Glitch counter:
  - Each cycle, glitch_count adds the number of flagging channels (0 to 3).
  - The sum saturates at 2^GLITCH_W-1 and never wraps.
  - clr_glitch=1 sets glitch_count to 0 and ignores glitches flagged in that same cycle.
- Enable:
  - While en=0, all cnt values are held at 0, a/b/c are forced to 0, and no glitches are flagged.
  - After en rises, a line already high at syncd needs the full DEBOUNCE_CYCLES before its output goes high.
  - en falling forces outputs to 0 at the next edge.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous output changes, with no arbitration. Resolving which input came first is the detector's job.
- Outputs are registered with no combinational path from any input to any output.

Decomposition:
- Shared package detector_pkg holds:
  - NUM_CH = 3
  - channel index constants CH_A = 0, CH_B = 1, CH_C = 2, matching the bit order of detector y
  - default DEBOUNCE_CYCLES and GLITCH_W values
- Sub-module debounce_ch (synchronizer, counter, output flop, glitch flag), instantiated NUM_CH times.
- The top level holds only the glitch adder, saturation and clear logic.

Test Plan:
- Reset, en=1, a_raw held 1 from before edge 0 -> a=0 through edge 4, a=1 after edge 5; b=c=0; glitch_count=0.
- b_raw high for exactly 2 cycles, then low -> b stays 0; glitch_count increments to 1 once, 2 cycles after b_raw falls.
- a_raw, b_raw and c_raw each pulse high for 1 cycle in the same cycle -> a/b/c stay 0; glitch_count goes 0 to 3 in a single cycle.
- Drive 300 single-cycle glitches on c_raw -> glitch_count saturates at 255 and holds.
  - Then assert clr_glitch for one cycle while a glitch flag fires -> glitch_count = 0 next cycle.
- a=1 steady, assert rst for 1 cycle while a_raw stays 1 -> a=0 after the rst edge, and a=1 again SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after rst deasserts.
- en=0 with c_raw=1 -> c stays 0 and glitch_count does not change.
  - Raise en -> c=1 after DEBOUNCE_CYCLES edges.
  - Drop en -> c=0 at the next edge.

Source files
------------

// File: rtl/detector_pkg.sv
// Shared constants for the first-signal detector and its input conditioner.
// Channel indices match the bit order of the detector's y output.
package detector_pkg;
  localparam int NUM_CH = 3;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_C   = 2;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_GLITCH_W        = 8;
  localparam int CNT_W               = 8;

  function automatic logic [1:0] count_set(input logic [NUM_CH-1:0] v);
    logic [1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + {1'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/signal_conditioner_if.sv
// Raw lines in, clean levels and glitch diagnostics out.
// The master drives the raw side; the conditioner is the slave.
interface signal_conditioner_if
  import detector_pkg::*;
  #(parameter int GLITCH_W = DEF_GLITCH_W);
  logic                en;
  logic                clr_glitch;
  logic                a_raw;
  logic                b_raw;
  logic                c_raw;
  logic                a;
  logic                b;
  logic                c;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output en, clr_glitch, a_raw, b_raw, c_raw,
    input  a, b, c, glitch_count
  );

  modport slave (
    input  en, clr_glitch, a_raw, b_raw, c_raw,
    output a, b, c, glitch_count
  );
endinterface

// File: rtl/debounce_ch.sv
// One channel: synchronizer chain, persistence counter, registered output.
// Output follows a new level SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after raw settles.
module debounce_ch
  import detector_pkg::*;
  #(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
  ) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic out,
    output logic glitch
  );

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   syncd;

  assign syncd = sync_q[SYNC_STAGES-1];

  // The synchronizer ignores en so a level is already settled when en rises.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (syncd == out) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      out <= syncd;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A differing run that collapsed before acceptance.
  assign glitch = en && (syncd == out) && (cnt != '0);
endmodule

// File: rtl/signal_conditioner.sv
// Three independent debounced channels feeding the detector, plus a saturating glitch tally.
// All outputs are registered; glitch_count lags the ended run by one edge.
module signal_conditioner
  import detector_pkg::*;
  #(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int GLITCH_W        = DEF_GLITCH_W
  ) (
    input logic                 clk,
    input logic                 rst,
    signal_conditioner_if.slave sc
  );

  logic [NUM_CH-1:0]   raw_vec;
  logic [NUM_CH-1:0]   out_vec;
  logic [NUM_CH-1:0]   glitch_vec;
  logic [1:0]          n_glitch;
  logic [GLITCH_W:0]   sum;
  logic [GLITCH_W-1:0] glitch_q;

  assign raw_vec[CH_A] = sc.a_raw;
  assign raw_vec[CH_B] = sc.b_raw;
  assign raw_vec[CH_C] = sc.c_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (sc.en),
      .raw   (raw_vec[i]),
      .out   (out_vec[i]),
      .glitch(glitch_vec[i])
    );
  end

  assign n_glitch = count_set(glitch_vec);
  // One spare bit catches overflow; at most 3 is added per cycle.
  assign sum = {1'b0, glitch_q} + (GLITCH_W+1)'(n_glitch);

  always_ff @(posedge clk) begin
    if (rst || sc.clr_glitch) glitch_q <= '0;
    else if (sum[GLITCH_W])   glitch_q <= '1;
    else                      glitch_q <= sum[GLITCH_W-1:0];
  end

  assign sc.a            = out_vec[CH_A];
  assign sc.b            = out_vec[CH_B];
  assign sc.c            = out_vec[CH_C];
  assign sc.glitch_count = glitch_q;
endmodule

// File: tb/tb_signal_conditioner.sv
// Scoreboard bench: driver steps a level-history model and queues expected outputs,
// a monitor pops one entry per clock and compares against the conditioner.
module tb_signal_conditioner;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int GW   = 8;
  localparam int GMAX = (1 << GW) - 1;

  typedef struct packed {
    logic          a;
    logic          b;
    logic          c;
    logic [GW-1:0] gc;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  int   total;
  int   bad;
  bit   done;

  // Model state: raw history per channel, accepted level, length of the current differing run.
  bit [7:0] hist[3];
  bit       lvl[3];
  int       run[3];
  int       gcount;

  signal_conditioner_if #(.GLITCH_W(GW)) sif ();

  signal_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .GLITCH_W       (GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sc (sif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int pending_flags();
    int n;
    n = 0;
    for (int ch = 0; ch < 3; ch++)
      if (sif.en && hist[ch][S-1] == lvl[ch] && run[ch] > 0) n++;
    return n;
  endfunction

  // Advance the model across the next rising edge, queue its outputs, then wait for the falling edge.
  task automatic cyc();
    exp_t e;
    bit   r[3];
    bit   seen;
    int   flags;
    r[0] = sif.a_raw;
    r[1] = sif.b_raw;
    r[2] = sif.c_raw;
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        hist[ch] = '0;
        lvl[ch]  = 1'b0;
        run[ch]  = 0;
      end
      gcount = 0;
    end else begin
      flags = 0;
      for (int ch = 0; ch < 3; ch++) begin
        seen = hist[ch][S-1];
        if (!sif.en) begin
          run[ch] = 0;
          lvl[ch] = 1'b0;
        end else if (seen != lvl[ch]) begin
          run[ch]++;
          if (run[ch] == D) begin
            lvl[ch] = seen;
            run[ch] = 0;
          end
        end else begin
          if (run[ch] > 0) flags++;
          run[ch] = 0;
        end
        hist[ch] = {hist[ch][6:0], r[ch]};
      end
      if (sif.clr_glitch)           gcount = 0;
      else if (gcount + flags > GMAX) gcount = GMAX;
      else                          gcount = gcount + flags;
    end
    e.a  = lvl[0];
    e.b  = lvl[1];
    e.c  = lvl[2];
    e.gc = GW'(gcount);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a", int'(sif.a), int'(e.a));
        chk("b", int'(sif.b), int'(e.b));
        chk("c", int'(sif.c), int'(e.c));
        chk("glitch_count", int'(sif.glitch_count), int'(e.gc));
      end else if (!done) begin
        chk("scoreboard_underrun", 0, 1);
      end
    end
  end

  initial begin : driver
    bit cleared;
    total = 0;
    bad   = 0;
    done  = 0;
    rst = 1'b1;
    sif.en = 1'b1;
    sif.clr_glitch = 1'b0;
    sif.a_raw = 1'b1;
    sif.b_raw = 1'b0;
    sif.c_raw = 1'b0;
    idle(2);
    rst = 1'b0;

    // a_raw already high: a rises on the sixth edge after reset.
    idle(5);
    chk("a_latency_before", int'(sif.a), 0);
    cyc();
    chk("a_latency_after", int'(sif.a), 1);
    idle(3);

    // Two-cycle b pulse is rejected and counted once.
    sif.b_raw = 1'b1;
    idle(2);
    sif.b_raw = 1'b0;
    idle(8);

    // Drop a, then a one-cycle pulse on all three lines together.
    sif.a_raw = 1'b0;
    idle(10);
    sif.a_raw = 1'b1;
    sif.b_raw = 1'b1;
    sif.c_raw = 1'b1;
    cyc();
    sif.a_raw = 1'b0;
    sif.b_raw = 1'b0;
    sif.c_raw = 1'b0;
    idle(6);

    // 300 single-cycle c glitches drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      sif.c_raw = 1'b1;
      cyc();
      sif.c_raw = 1'b0;
      cyc();
    end
    idle(4);
    chk("glitch_saturated", int'(sif.glitch_count), GMAX);

    // Clear coinciding with a firing glitch flag.
    cleared = 0;
    for (int i = 0; i < 8 && !cleared; i++) begin
      sif.c_raw = ~sif.c_raw;
      if (pending_flags() > 0) begin
        sif.clr_glitch = 1'b1;
        cyc();
        sif.clr_glitch = 1'b0;
        chk("glitch_cleared", int'(sif.glitch_count), 0);
        cleared = 1;
      end else begin
        cyc();
      end
    end
    chk("clear_attempted", int'(cleared), 1);
    sif.c_raw = 1'b0;
    idle(6);

    // Reset while a is steady high.
    sif.a_raw = 1'b1;
    idle(10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("a_after_rst", int'(sif.a), 0);
    idle(8);

    // Enable gating on c.
    sif.a_raw = 1'b0;
    sif.en = 1'b0;
    sif.c_raw = 1'b1;
    idle(10);
    chk("c_while_disabled", int'(sif.c), 0);
    sif.en = 1'b1;
    idle(D - 1);
    chk("c_before_enable_latency", int'(sif.c), 0);
    cyc();
    chk("c_after_enable_latency", int'(sif.c), 1);
    idle(2);
    sif.en = 1'b0;
    cyc();
    chk("c_after_en_drop", int'(sif.c), 0);
    sif.en = 1'b1;
    idle(3);

    // Randomized raw levels with occasional enable, clear and reset activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) sif.a_raw = ~sif.a_raw;
      if ($urandom_range(0, 4) == 0) sif.b_raw = ~sif.b_raw;
      if ($urandom_range(0, 2) == 0) sif.c_raw = ~sif.c_raw;
      if ($urandom_range(0, 149) == 0) sif.en = ~sif.en;
      sif.clr_glitch = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    rst = 1'b0;
    sif.clr_glitch = 1'b0;
    idle(4);

    done = 1;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
